// File: rtl/alu_pkg.sv
// Shared types for the sequential BCD ALU: operation and FSM encodings, flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_ACC = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_CONV = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic op_e op_next(input op_e op);
    case (op)
      OP_ADD:  return OP_SUB;
      OP_SUB:  return OP_AND;
      OP_AND:  return OP_OR;
      OP_OR:   return OP_XOR;
      OP_XOR:  return OP_ACC;
      OP_ACC:  return OP_ADD;
      default: return OP_ADD;
    endcase
  endfunction

  function automatic logic [5:0] op_onehot(input op_e op);
    case (op)
      OP_ADD:  return 6'b000001;
      OP_SUB:  return 6'b000010;
      OP_AND:  return 6'b000100;
      OP_OR:   return 6'b001000;
      OP_XOR:  return 6'b010000;
      OP_ACC:  return 6'b100000;
      default: return 6'b000001;
    endcase
  endfunction

endpackage

// File: rtl/bcd_dd_seq.sv
// Sequential double-dabble converter. The first iteration runs on the load edge, so
// done_o pulses in the cycle after the last of WIDTH iterations, with bcd_o final.
module bcd_dd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      bin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [4*DIGITS-1:0] bcd_q;
  logic [WIDTH-1:0]    shift_q;
  logic [CW-1:0]       cnt_q;
  logic                done_q;

  function automatic logic [4*DIGITS+WIDTH-1:0] dd_step(
    input logic [4*DIGITS-1:0] bcd,
    input logic [WIDTH-1:0]    sh
  );
    logic [4*DIGITS-1:0] adj;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    return {adj, sh} << 1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        {bcd_q, shift_q} <= dd_step({(4*DIGITS){1'b0}}, bin_i);
        cnt_q            <= CW'(WIDTH - 1);
      end else if (cnt_q != '0) begin
        {bcd_q, shift_q} <= dd_step(bcd_q, shift_q);
        cnt_q            <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = done_q;
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/alu_seq_bcd.sv
// Sequential ALU with accumulator, stepped op select and BCD display view.
// Define ALU_SAT_EN to clamp signed overflow on ADD/SUB/ACC instead of wrapping.
module alu_seq_bcd
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic                start_i,
  input  logic                op_step_i,
  output logic [5:0]          op_onehot_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [WIDTH-1:0]    result_o,
  output logic [3:0]          flags_o,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic                neg_o
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_e              state_q;
  op_e                 op_q;
  op_e                 lop_q;
  logic [5:0]          op_onehot_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    acc_q;
  logic [WIDTH-1:0]    res_q;
  logic [3:0]          flg_q;
  logic                sneg_q;
  logic                busy_q;
  logic                done_q;
  logic [WIDTH-1:0]    result_q;
  logic [3:0]          flags_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic                neg_q;

  logic [WIDTH-1:0]    opa_s;
  logic [WIDTH-1:0]    opb_s;
  logic                cin_s;
  logic [WIDTH:0]      sum_s;
  logic                ovf_s;
  logic [WIDTH-1:0]    res_s;
  logic                c_s;
  logic                v_s;
  logic                signed_s;
  logic                neg_s;
  logic [WIDTH-1:0]    mag_s;
  logic [3:0]          flags_s;

  logic                conv_load_s;
  logic                conv_busy_s;
  logic                conv_done_s;
  logic [4*DIGITS-1:0] conv_bcd_s;

  // Datapath for the latched operation; SUB is A + ~B + 1 so C means no-borrow.
  always_comb begin
    opa_s    = a_q;
    opb_s    = b_q;
    cin_s    = 1'b0;
    res_s    = '0;
    c_s      = 1'b0;
    v_s      = 1'b0;
    signed_s = 1'b0;
    case (lop_q)
      OP_SUB: begin
        opb_s = ~b_q;
        cin_s = 1'b1;
      end
      OP_ACC: begin
        opa_s = acc_q;
        opb_s = a_q;
      end
      default: begin
        opa_s = a_q;
        opb_s = b_q;
      end
    endcase
    sum_s = {1'b0, opa_s} + {1'b0, opb_s} + {{WIDTH{1'b0}}, cin_s};
    ovf_s = (opa_s[WIDTH-1] == opb_s[WIDTH-1]) && (sum_s[WIDTH-1] != opa_s[WIDTH-1]);
    case (lop_q)
      OP_ADD, OP_SUB, OP_ACC: begin
        signed_s = 1'b1;
        c_s      = sum_s[WIDTH];
        v_s      = ovf_s;
`ifdef ALU_SAT_EN
        if (ovf_s) begin
          res_s = opa_s[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
          res_s = sum_s[WIDTH-1:0];
        end
`else
        res_s = sum_s[WIDTH-1:0];
`endif
      end
      OP_AND:  res_s = a_q & b_q;
      OP_OR:   res_s = a_q | b_q;
      OP_XOR:  res_s = a_q ^ b_q;
      default: res_s = '0;
    endcase
    flags_s         = 4'b0000;
    flags_s[FLAG_N] = res_s[WIDTH-1];
    flags_s[FLAG_Z] = (res_s == '0);
    flags_s[FLAG_C] = c_s;
    flags_s[FLAG_V] = v_s;
    neg_s = signed_s & res_s[WIDTH-1];
    // Two's-complement negation also maps the most-negative value onto 2^(WIDTH-1).
    if (neg_s) begin
      mag_s = ~res_s + {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      mag_s = res_s;
    end
  end

  assign conv_load_s = (state_q == ST_EXEC);

  bcd_dd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk    (clk),
    .reset  (reset),
    .load_i (conv_load_s),
    .bin_i  (mag_s),
    .busy_o (conv_busy_s),
    .done_o (conv_done_s),
    .bcd_o  (conv_bcd_s)
  );

  // Control FSM, op selection, accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      lop_q       <= OP_ADD;
      op_onehot_q <= 6'b000001;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      flg_q       <= 4'b0000;
      sneg_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      bcd_q       <= '0;
      neg_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (op_step_i) begin
        op_q        <= op_next(op_q);
        op_onehot_q <= op_onehot(op_next(op_q));
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            lop_q   <= op_q;
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q  <= res_s;
          flg_q  <= flags_s;
          sneg_q <= neg_s;
          if (lop_q == OP_ACC) begin
            acc_q <= res_s;
          end
          state_q <= ST_CONV;
        end
        ST_CONV: begin
          if (conv_done_s && !conv_busy_s) begin
            result_q <= res_q;
            flags_q  <= flg_q;
            bcd_q    <= conv_bcd_s;
            neg_q    <= sneg_q;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign op_onehot_o = op_onehot_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign flags_o     = flags_q;
  assign bcd_o       = bcd_q;
  assign neg_o       = neg_q;

endmodule

// File: tb/tb_alu_seq_bcd.sv
// Directed-vector bench for alu_seq_bcd at WIDTH=8, DIGITS=3.
module tb_alu_seq_bcd;

  logic        clk;
  logic        reset;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        start_i;
  logic        op_step_i;
  logic [5:0]  op_onehot_o;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  result_o;
  logic [3:0]  flags_o;
  logic [11:0] bcd_o;
  logic        neg_o;

  int n_cmp;
  int n_bad;
  int lat;
  int n_done;

  alu_seq_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_i         (a_i),
    .b_i         (b_i),
    .start_i     (start_i),
    .op_step_i   (op_step_i),
    .op_onehot_o (op_onehot_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .flags_o     (flags_o),
    .bcd_o       (bcd_o),
    .neg_o       (neg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step_op();
    @(negedge clk) op_step_i = 1'b1;
    @(negedge clk) op_step_i = 1'b0;
  endtask

  // Issues one start; returns at the negedge of the done cycle (or after the bound).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit step_too, input bit extra_start, output int n);
    @(negedge clk);
    a_i = a;
    b_i = b;
    start_i = 1'b1;
    op_step_i = step_too;
    @(negedge clk);
    start_i = 1'b0;
    op_step_i = 1'b0;
    n = 1;
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    while (!done_o && n < 40) begin
      @(negedge clk);
      n++;
      start_i = (extra_start && n == 3);
    end
    start_i = 1'b0;
    chk("busy_in_done", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic watch(input int cycles, output int dones);
    dones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done_o) dones++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    a_i = 8'd0;
    b_i = 8'd0;
    start_i = 1'b0;
    op_step_i = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_onehot", {26'd0, op_onehot_o}, 32'h01);
    chk("rst_result", {24'd0, result_o}, 32'h0);
    chk("rst_flags",  {28'd0, flags_o}, 32'h0);
    chk("rst_bcd",    {20'd0, bcd_o}, 32'h0);
    chk("rst_busy",   {31'd0, busy_o}, 32'd0);
    chk("rst_neg",    {31'd0, neg_o}, 32'd0);

    run_op(8'd100, 8'd27, 1'b0, 1'b0, lat);
    chk("add1_lat",    lat, 32'd10);
    chk("add1_result", {24'd0, result_o}, 32'h7F);
    chk("add1_flags",  {28'd0, flags_o}, 32'h0);
    chk("add1_bcd",    {20'd0, bcd_o}, 32'h127);
    chk("add1_neg",    {31'd0, neg_o}, 32'd0);

    // Back-to-back: this start lands in the cycle right after DONE.
    run_op(8'd100, 8'd100, 1'b0, 1'b0, lat);
    chk("add2_lat", lat, 32'd10);
`ifdef ALU_SAT_EN
    chk("add2_result", {24'd0, result_o}, 32'h7F);
    chk("add2_flags",  {28'd0, flags_o}, 32'h1);
    chk("add2_bcd",    {20'd0, bcd_o}, 32'h127);
    chk("add2_neg",    {31'd0, neg_o}, 32'd0);
`else
    chk("add2_result", {24'd0, result_o}, 32'hC8);
    chk("add2_flags",  {28'd0, flags_o}, 32'h9);
    chk("add2_bcd",    {20'd0, bcd_o}, 32'h056);
    chk("add2_neg",    {31'd0, neg_o}, 32'd1);
`endif

    step_op();
    chk("onehot_sub", {26'd0, op_onehot_o}, 32'h02);
    run_op(8'd5, 8'd5, 1'b0, 1'b1, lat);
    chk("sub_lat",    lat, 32'd10);
    chk("sub_result", {24'd0, result_o}, 32'h0);
    chk("sub_flags",  {28'd0, flags_o}, 32'h6);
    chk("sub_bcd",    {20'd0, bcd_o}, 32'h0);
    @(negedge clk);
    chk("busy_clear", {31'd0, busy_o}, 32'd0);
    watch(15, n_done);
    chk("no_extra_done", n_done, 32'd0);
    chk("sub_hold",   {28'd0, flags_o}, 32'h6);

    step_op();
    step_op();
    chk("onehot_or", {26'd0, op_onehot_o}, 32'h08);
    run_op(8'h80, 8'h01, 1'b0, 1'b0, lat);
    chk("or_result", {24'd0, result_o}, 32'h81);
    chk("or_flags",  {28'd0, flags_o}, 32'h8);
    chk("or_bcd",    {20'd0, bcd_o}, 32'h129);
    chk("or_neg",    {31'd0, neg_o}, 32'd0);

    step_op();
    // Start and step together: XOR executes, selection moves on to ACC.
    run_op(8'hF0, 8'hFF, 1'b1, 1'b0, lat);
    chk("xor_result", {24'd0, result_o}, 32'h0F);
    chk("xor_flags",  {28'd0, flags_o}, 32'h0);
    chk("xor_bcd",    {20'd0, bcd_o}, 32'h015);
    chk("onehot_acc", {26'd0, op_onehot_o}, 32'h20);

    run_op(8'd50, 8'd0, 1'b0, 1'b0, lat);
    chk("acc1_result", {24'd0, result_o}, 32'h32);
    chk("acc1_bcd",    {20'd0, bcd_o}, 32'h050);
    run_op(8'd50, 8'd0, 1'b0, 1'b0, lat);
    chk("acc2_result", {24'd0, result_o}, 32'h64);
    chk("acc2_bcd",    {20'd0, bcd_o}, 32'h100);
    run_op(8'd50, 8'd0, 1'b0, 1'b0, lat);
`ifdef ALU_SAT_EN
    chk("acc3_result", {24'd0, result_o}, 32'h7F);
    chk("acc3_flags",  {28'd0, flags_o}, 32'h1);
    chk("acc3_bcd",    {20'd0, bcd_o}, 32'h127);
    chk("acc3_neg",    {31'd0, neg_o}, 32'd0);
`else
    chk("acc3_result", {24'd0, result_o}, 32'h96);
    chk("acc3_flags",  {28'd0, flags_o}, 32'h9);
    chk("acc3_bcd",    {20'd0, bcd_o}, 32'h106);
    chk("acc3_neg",    {31'd0, neg_o}, 32'd1);
`endif

    // Abort during CONV.
    @(negedge clk);
    a_i = 8'd1;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy",   {31'd0, busy_o}, 32'd0);
    chk("abort_result", {24'd0, result_o}, 32'h0);
    chk("abort_flags",  {28'd0, flags_o}, 32'h0);
    chk("abort_bcd",    {20'd0, bcd_o}, 32'h0);
    chk("abort_onehot", {26'd0, op_onehot_o}, 32'h01);
    reset = 1'b0;
    watch(15, n_done);
    chk("abort_no_done", n_done, 32'd0);

    run_op(8'h80, 8'h00, 1'b0, 1'b0, lat);
    chk("minneg_result", {24'd0, result_o}, 32'h80);
    chk("minneg_flags",  {28'd0, flags_o}, 32'h8);
    chk("minneg_bcd",    {20'd0, bcd_o}, 32'h128);
    chk("minneg_neg",    {31'd0, neg_o}, 32'd1);

    repeat (5) step_op();
    run_op(8'd7, 8'd0, 1'b0, 1'b0, lat);
    chk("acc_cleared", {24'd0, result_o}, 32'h07);
    chk("acc_cleared_bcd", {20'd0, bcd_o}, 32'h007);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
